// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-RAM arbiter.
package dmem_pkg;

  typedef enum logic {
    CORE_OWN = 1'b0,
    M_OWN    = 1'b1
  } arb_state_t;

  localparam int MAX_WAIT_DEF = 4;

  // Counter width able to hold 0..max inclusive.
  function automatic int wait_width(input int max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Saturating count of consecutive cycles a pending secondary request was denied.
module dmem_wait_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  logic [W-1:0] cnt;

  assign sat = (cnt == W'(MAX));

  always_ff @(posedge CLK) begin
    if (!RESET_N)        cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the core (priority) and a secondary
// master that is guaranteed a slot after MAX_WAIT denied cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  core_req,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic                  core_we,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  input  logic                  m_req,
  input  logic                  m_lock,
  input  logic [ADDR_WIDTH-1:0] m_addr,
  input  logic                  m_we,
  input  logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_ack,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int WAIT_W = wait_width(MAX_WAIT);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
  } ram_req_t;

  arb_state_t state;
  logic       grant_m;
  logic       wait_sat;
  ram_req_t   core_rq, m_rq, sel_rq;

  dmem_wait_counter #(.MAX(MAX_WAIT), .W(WAIT_W)) u_wait (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clr     (grant_m | ~m_req),
    .inc     (m_req & ~grant_m),
    .sat     (wait_sat)
  );

  // Gating with RESET_N keeps a reset cycle free of acks, stalls and writes.
  always_comb begin
    grant_m = 1'b0;
    if (RESET_N) begin
      case (state)
        CORE_OWN: grant_m = m_req & (~core_req | wait_sat);
        M_OWN:    grant_m = m_req;
        default:  grant_m = 1'b0;
      endcase
    end
  end

  assign core_rq = '{addr: core_addr, we: core_req & core_we, wdata: core_wdata};
  assign m_rq    = '{addr: m_addr, we: m_we, wdata: m_wdata};
  assign sel_rq  = grant_m ? m_rq : core_rq;

  assign ram_addr   = sel_rq.addr;
  assign ram_wdata  = sel_rq.wdata;
  assign ram_we     = RESET_N & sel_rq.we;
  assign core_rdata = ram_rdata;
  assign core_stall = core_req & grant_m;
  assign m_ack      = grant_m;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state   <= CORE_OWN;
      m_rdata <= '0;
    end else begin
      if (grant_m && !m_we) m_rdata <= ram_rdata;
      case (state)
        CORE_OWN: if (grant_m && m_lock)  state <= M_OWN;
        M_OWN:    if (!m_req || !m_lock)  state <= CORE_OWN;
        default:  state <= CORE_OWN;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random traffic
// against a request-age / shadow-memory reference model.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          core_req, core_we, m_req, m_lock, m_we;
  logic [AW-1:0] core_addr, m_addr;
  logic [DW-1:0] core_wdata, m_wdata;
  logic [DW-1:0] core_rdata, m_rdata, ram_wdata, ram_rdata;
  logic          core_stall, m_ack, ram_we;
  logic [AW-1:0] ram_addr;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .core_req(core_req), .core_addr(core_addr), .core_we(core_we),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .m_req(m_req), .m_lock(m_lock), .m_addr(m_addr), .m_we(m_we),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  // Unregistered-read RAM
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign ram_rdata = mem[ram_addr];
  always @(posedge CLK) if (ram_we) mem[ram_addr] <= ram_wdata;

  typedef struct {
    logic          ack;
    logic          stall;
    logic          we;
    logic [DW-1:0] m_rdata;
    bit            rd_chk;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_m_rdata = '0;
  bit            owned = 0;
  int            age   = 0;
  bit            last_g = 0;

  logic          ack_s, stall_s;
  logic [DW-1:0] rd_s, mrd_s;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("m_ack", {31'd0, m_ack}, {31'd0, e.ack});
      chk("core_stall", {31'd0, core_stall}, {31'd0, e.stall});
      chk("ram_we", {31'd0, ram_we}, {31'd0, e.we});
      chk("m_rdata", m_rdata, e.m_rdata);
      if (e.rd_chk) chk("core_rdata", core_rdata, e.rd);
    end
  end

  // One clock: predict this cycle from current inputs, then advance the model.
  task automatic step();
    exp_t e;
    bit   g;
    g = 0;
    e.m_rdata = ref_m_rdata;
    e.rd = '0;
    if (!RESET_N) begin
      e.ack = 0; e.stall = 0; e.we = 0; e.rd_chk = 0;
      sb.push_back(e);
      owned = 0; age = 0; ref_m_rdata = '0;
    end else begin
      // A pending request has waited `age` denied cycles; MW of them buys a slot.
      g = m_req && (owned || !core_req || age >= MW);
      e.ack    = g;
      e.stall  = core_req && g;
      e.we     = g ? m_we : (core_req && core_we);
      e.rd_chk = core_req && !core_we && !g;
      e.rd     = ref_mem[core_addr];
      sb.push_back(e);
      if (g && m_we)              ref_mem[m_addr] = m_wdata;
      else if (g)                 ref_m_rdata = ref_mem[m_addr];
      else if (core_req && core_we) ref_mem[core_addr] = core_wdata;
      if (g || !m_req) age = 0;
      else if (age < MW) age++;
      owned = g && m_lock;
    end
    last_g = g;
    @(negedge CLK);
    ack_s = m_ack; stall_s = core_stall; rd_s = core_rdata; mrd_s = m_rdata;
    @(posedge CLK);
    #1;
  endtask

  task automatic new_req();
    m_req   = 1;
    m_we    = 1'($urandom % 2);
    m_addr  = AW'($urandom % 16);
    m_wdata = $urandom;
    m_lock  = ($urandom % 6) == 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ack_cyc, n_st, n_ack, steps;
    for (int i = 0; i < (1<<AW); i++) begin mem[i] = '0; ref_mem[i] = '0; end
    RESET_N = 0;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    m_req = 0; m_lock = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    repeat (2) @(posedge CLK);
    #1;

    // Reset holds everything quiet even with both masters requesting writes
    core_req = 1; core_we = 1; m_req = 1; m_we = 1; m_lock = 1;
    core_addr = 10'h050; m_addr = 10'h051; core_wdata = 32'h1111; m_wdata = 32'h2222;
    step();
    chk("rst_ack", {31'd0, ack_s}, 32'd0);
    chk("rst_mrdata", mrd_s, 32'd0);
    RESET_N = 1; core_req = 0; core_we = 0; m_req = 0; m_we = 0; m_lock = 0;
    step();

    // Core only
    core_req = 1; core_we = 1; core_addr = 10'h010; core_wdata = 32'hDEADBEEF;
    step();
    core_we = 0;
    step();
    chk("core_rd_010", rd_s, 32'hDEADBEEF);
    chk("core_only_stall", {31'd0, stall_s}, 32'd0);

    // Idle-slot grant
    core_req = 0; m_req = 1; m_we = 0; m_addr = 10'h010;
    step();
    chk("idle_ack", {31'd0, ack_s}, 32'd1);
    m_req = 0;
    step();
    chk("idle_mrdata", mrd_s, 32'hDEADBEEF);

    // Starvation bound
    core_req = 1; core_we = 0; core_addr = 10'h000;
    m_req = 1; m_we = 1; m_addr = 10'h020; m_wdata = 32'h12345678;
    ack_cyc = 0; n_st = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (stall_s) n_st++;
      if (ack_s && ack_cyc == 0) begin ack_cyc = i; m_req = 0; end
    end
    chk("starve_ack_cycle", ack_cyc, MW + 1);
    chk("starve_stalls", n_st, 1);
    core_addr = 10'h020;
    step();
    chk("core_rd_020", rd_s, 32'h12345678);

    // Locked burst
    m_lock = 1; m_req = 1; m_we = 1; n_ack = 0; n_st = 0; steps = 0;
    for (int i = 0; i < 8; i++) begin
      m_addr = AW'(i); m_wdata = DW'(i);
      for (int k = 0; k < 20; k++) begin
        step(); steps++;
        if (stall_s) n_st++;
        if (ack_s) begin n_ack++; break; end
      end
    end
    chk("burst_acks", n_ack, 8);
    chk("burst_steps", steps, MW + 8);
    chk("burst_stalls", n_st, 8);
    m_lock = 0; m_req = 0;
    step();
    chk("burst_end_stall", {31'd0, stall_s}, 32'd0);
    m_req = 1; m_we = 0;
    step();
    chk("burst_core_own", {31'd0, ack_s}, 32'd0);
    m_req = 0; core_addr = 10'h005;
    step();
    chk("burst_rd_005", rd_s, 32'd5);

    // Abandoned request
    core_addr = 10'h000; m_req = 1; m_we = 1; m_addr = 10'h030; m_wdata = 32'hAAAA5555;
    n_ack = 0;
    repeat (2) begin step(); if (ack_s) n_ack++; end
    m_req = 0;
    step();
    chk("abandon_acks", n_ack, 0);
    core_addr = 10'h030;
    step();
    chk("abandon_rd_030", rd_s, 32'd0);
    m_req = 1; m_we = 0; ack_cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (ack_s && ack_cyc == 0) begin ack_cyc = i; m_req = 0; end
    end
    chk("abandon_wait_cleared", ack_cyc, MW + 1);

    // Reset during a locked write
    core_req = 0; m_lock = 1; m_req = 1; m_we = 0; m_addr = 10'h010;
    step();
    m_we = 1; m_addr = 10'h040; m_wdata = 32'hFFFFFFFF; RESET_N = 0;
    step();
    chk("rstlock_ack", {31'd0, ack_s}, 32'd0);
    chk("rstlock_mrdata_pre", mrd_s, 32'hDEADBEEF);
    RESET_N = 1; m_req = 0; m_lock = 0;
    step();
    chk("rstlock_mrdata", mrd_s, 32'd0);
    core_req = 1; core_we = 0; core_addr = 10'h040; m_req = 1; m_we = 0;
    step();
    chk("rstlock_core_own", {31'd0, ack_s}, 32'd0);
    chk("rstlock_rd_040", rd_s, 32'd0);
    m_req = 0;
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      core_req   = ($urandom % 4) != 0;
      core_we    = 1'($urandom % 2);
      core_addr  = AW'($urandom % 16);
      core_wdata = $urandom;
      if (m_req && last_g) begin
        if ($urandom % 2) m_req = 0; else new_req();
      end else if (m_req) begin
        if ($urandom % 40 == 0) m_req = 0;
      end else if ($urandom % 3 == 0) begin
        new_req();
      end
      RESET_N = ($urandom % 200) != 0;
      step();
    end

    RESET_N = 1; core_req = 0; m_req = 0; m_lock = 0;
    step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
